// File: rtl/dsp_pkg.sv
// Shared encodings and arithmetic helpers for the decimation datapath.
package dsp_pkg;

   localparam logic MODE_PICK = 1'b0;
   localparam logic MODE_AVG  = 1'b1;

   localparam int unsigned SAT_W = 64;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Clamp a signed value into the signed range of 'width' bits.
   function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] value,
                                                     input int unsigned width);
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = $signed((SAT_W'(1) << (width - 1)) - SAT_W'(1));
      min_v = ~max_v;
      if (value > max_v)
         sat_s = max_v;
      else if (value < min_v)
         sat_s = min_v;
      else
         sat_s = value;
   endfunction

endpackage

// File: rtl/dec_acc_ch.sv
// One channel of the decimator: boxcar accumulator, shift, saturate, PICK bypass.
module dec_acc_ch
   import dsp_pkg::*;
#(
   parameter int unsigned DW = 16,
   parameter int unsigned RW = 8,
   parameter int unsigned SW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          smp,
   input  logic          first,
   input  logic          pick_hit,
   input  logic          avg_hit,
   input  logic [SW-1:0] shift,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          sat
);

   localparam int unsigned AW = DW + RW;

   logic signed [AW-1:0]    acc;
   logic signed [AW-1:0]    acc_nxt;
   logic signed [AW-1:0]    shifted;
   logic signed [SAT_W-1:0] sat_full;
   logic [DW-1:0]           avg_val;
   logic                    clipped;

   // Sum including the current sample so the frame result needs no extra cycle.
   always_comb begin
      acc_nxt  = first ? AW'($signed(din)) : acc + AW'($signed(din));
      shifted  = acc_nxt >>> shift;
      sat_full = sat_s(SAT_W'(shifted), DW);
      clipped  = (sat_full != SAT_W'(shifted));
      avg_val  = DW'(sat_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (smp)
         acc <= acc_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
         sat  <= 1'b0;
      end else if (pick_hit) begin
         dout <= din;
         sat  <= 1'b0;
      end else if (avg_hit) begin
         dout <= avg_val;
         sat  <= clipped;
      end else begin
         sat  <= 1'b0;
      end
   end

endmodule

// File: rtl/data_decimator.sv
// Multi-channel sample-rate reducer: shared framing/config, per-channel datapaths.
module data_decimator
   import dsp_pkg::*;
#(
   parameter int unsigned N_CH = 2,
   parameter int unsigned DW   = 16,
   parameter int unsigned RW   = 8,
   parameter int unsigned SW   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH*DW-1:0]   din,
   input  logic                 din_vld,
   input  logic [RW-1:0]        cfg_ratio,
   input  logic [RW-1:0]        cfg_phase,
   input  logic                 cfg_mode,
   input  logic [SW-1:0]        cfg_shift,
   input  logic                 cfg_load,
   output logic [N_CH*DW-1:0]   dout,
   output logic                 dout_vld,
   output logic [N_CH-1:0]      dout_sat
);

   logic [RW-1:0] ratio_a;
   logic [RW-1:0] phase_a;
   logic          mode_a;
   logic [SW-1:0] shift_a;
   logic [RW-1:0] cnt;
   state_t        state;

   logic [RW-1:0] ratio_s;
   logic [RW-1:0] phase_s;
   logic          smp;
   logic          first;
   logic          last;
   logic          pick_hit;
   logic          avg_hit;
   logic          clr;

   // A sample coinciding with cfg_load belongs to no frame and is dropped.
   always_comb begin
      ratio_s  = (cfg_ratio == '0) ? RW'(1) : cfg_ratio;
      phase_s  = (cfg_phase >= ratio_s) ? ratio_s - RW'(1) : cfg_phase;
      smp      = din_vld & ~cfg_load;
      first    = (cnt == '0);
      last     = (cnt == ratio_a - RW'(1));
      pick_hit = smp & (mode_a == MODE_PICK) & (cnt == phase_a);
      avg_hit  = smp & (mode_a == MODE_AVG) & last;
      clr      = cfg_load | ((state == ST_LOAD) & ~din_vld);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ratio_a  <= RW'(1);
         phase_a  <= '0;
         mode_a   <= MODE_PICK;
         shift_a  <= '0;
         cnt      <= '0;
         state    <= ST_LOAD;
         dout_vld <= 1'b0;
      end else begin
         dout_vld <= pick_hit | avg_hit;
         case (state)
            ST_LOAD: state <= cfg_load ? ST_LOAD : ST_RUN;
            ST_RUN:  state <= cfg_load ? ST_LOAD : ST_RUN;
            default: state <= ST_LOAD;
         endcase
         if (cfg_load) begin
            ratio_a <= ratio_s;
            phase_a <= phase_s;
            mode_a  <= cfg_mode;
            shift_a <= cfg_shift;
            cnt     <= '0;
         end else if (din_vld) begin
            cnt <= last ? '0 : cnt + RW'(1);
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      dec_acc_ch #(
         .DW (DW),
         .RW (RW),
         .SW (SW)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .clr      (clr),
         .smp      (smp),
         .first    (first),
         .pick_hit (pick_hit),
         .avg_hit  (avg_hit),
         .shift    (shift_a),
         .din      (din[k*DW +: DW]),
         .dout     (dout[k*DW +: DW]),
         .sat      (dout_sat[k])
      );
   end

endmodule

// File: tb/tb_data_decimator.sv
// Scoreboard bench for data_decimator: a behavioural model queues expected frames.
module tb_data_decimator;

   localparam int unsigned N_CH = 4;
   localparam int unsigned DW   = 16;
   localparam int unsigned RW   = 8;
   localparam int unsigned SW   = 4;
   localparam int unsigned BW   = N_CH * DW;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [BW-1:0]  din = '0;
   logic           din_vld = 1'b0;
   logic [RW-1:0]  cfg_ratio = '0;
   logic [RW-1:0]  cfg_phase = '0;
   logic           cfg_mode = 1'b0;
   logic [SW-1:0]  cfg_shift = '0;
   logic           cfg_load = 1'b0;
   logic [BW-1:0]  dout;
   logic           dout_vld;
   logic [N_CH-1:0] dout_sat;

   data_decimator #(
      .N_CH (N_CH),
      .DW   (DW),
      .RW   (RW),
      .SW   (SW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_vld   (din_vld),
      .cfg_ratio (cfg_ratio),
      .cfg_phase (cfg_phase),
      .cfg_mode  (cfg_mode),
      .cfg_shift (cfg_shift),
      .cfg_load  (cfg_load),
      .dout      (dout),
      .dout_vld  (dout_vld),
      .dout_sat  (dout_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [BW-1:0]   d;
      logic [N_CH-1:0] s;
      int              due;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [BW-1:0] hold_v = '0;

   int     m_ratio, m_phase, m_shift, m_cnt;
   logic   m_mode;
   longint m_acc[N_CH];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_ratio = 1; m_phase = 0; m_mode = 1'b0; m_shift = 0; m_cnt = 0;
      for (int k = 0; k < N_CH; k++) m_acc[k] = 0;
      q.delete();
      hold_v = '0;
   endtask

   // Drive one cycle of input and advance the reference model alongside it.
   task automatic step(input logic vld, input logic ld, input logic [BW-1:0] d);
      exp_t   e;
      longint x, s, mx;
      din = d; din_vld = vld; cfg_load = ld;
      mx = (longint'(1) <<< (DW - 1)) - 1;
      if (ld) begin
         m_cnt = 0;
         for (int k = 0; k < N_CH; k++) m_acc[k] = 0;
      end else if (vld) begin
         e.due = cyc + 1;
         e.s = '0;
         e.d = '0;
         if (!m_mode) begin
            if (m_cnt == m_phase) begin
               e.d = d;
               q.push_back(e);
            end
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               x = longint'($signed(d[k*DW +: DW]));
               m_acc[k] = (m_cnt == 0) ? x : m_acc[k] + x;
               s = m_acc[k] >>> m_shift;
               if (s > mx) begin s = mx; e.s[k] = 1'b1; end
               else if (s < -mx - 1) begin s = -mx - 1; e.s[k] = 1'b1; end
               e.d[k*DW +: DW] = DW'(s);
            end
            if (m_cnt == m_ratio - 1) q.push_back(e);
         end
         m_cnt = (m_cnt == m_ratio - 1) ? 0 : m_cnt + 1;
      end
      @(posedge clk);
      #1;
      din_vld = 1'b0; cfg_load = 1'b0;
   endtask

   task automatic load(input int r, input int ph, input logic md, input int sh,
                       input logic vld, input logic [BW-1:0] d);
      cfg_ratio = RW'(r); cfg_phase = RW'(ph); cfg_mode = md; cfg_shift = SW'(sh);
      m_ratio = (r == 0) ? 1 : r;
      m_phase = (ph >= m_ratio) ? m_ratio - 1 : ph;
      m_mode  = md;
      m_shift = sh;
      step(vld, 1'b1, d);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_dout", 64'(dout), 64'(0));
      check("rst_vld", 64'(dout_vld), 64'(0));
      check("rst_sat", 64'(dout_sat), 64'(0));
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   function automatic logic [BW-1:0] ramp(input int i);
      logic [BW-1:0] r;
      for (int k = 0; k < N_CH; k++) r[k*DW +: DW] = DW'(i + k * 7);
      return r;
   endfunction

   function automatic logic [BW-1:0] splat(input int v);
      logic [BW-1:0] r;
      for (int k = 0; k < N_CH; k++) r[k*DW +: DW] = DW'(v);
      return r;
   endfunction

   // Output monitor: pops the scoreboard on strobes, checks hold/idle otherwise.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (dout_vld) begin
            if (q.size() == 0) begin
               check("spurious_vld", 64'(dout_vld), 64'(0));
            end else begin
               e = q.pop_front();
               check("latency", 64'(cyc), 64'(e.due));
               check("dout", 64'(dout), 64'(e.d));
               check("sat", 64'(dout_sat), 64'(e.s));
               hold_v = e.d;
            end
         end else begin
            check("hold", 64'(dout), 64'(hold_v));
            check("sat_idle", 64'(dout_sat), 64'(0));
            if (q.size() > 0 && q[0].due <= cyc) begin
               check("missing_vld", 64'(dout_vld), 64'(1));
               void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [BW-1:0] dflt;
      int n;
      dflt = {16'h8000, 16'hFFFF, 16'h0001, 16'h1234};
      #3;
      do_reset();

      // Pass-through defaults
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, dflt);
      check("def_ch0", 64'(dout[15:0]), 64'(16'h1234));

      // PICK R=20 phase=2, continuous then gapped
      load(20, 2, 1'b0, 0, 1'b0, '0);
      for (int i = 0; i < 65; i++) step(1'b1, 1'b0, ramp(i));
      check("pick_cont", 64'(dout[15:0]), 64'(62));
      load(20, 2, 1'b0, 0, 1'b0, '0);
      n = 0;
      while (n < 45) begin
         if ($urandom_range(0, 2) != 0) begin
            step(1'b1, 1'b0, ramp(n));
            n++;
         end else begin
            step(1'b0, 1'b0, ramp(999));
         end
      end
      check("pick_gap", 64'(dout[15:0]), 64'(42));

      // Phase clamp and ratio 0
      load(4, 9, 1'b0, 0, 1'b0, '0);
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, ramp(i));
      check("phase_clamp", 64'(dout[15:0]), 64'(11));
      load(0, 5, 1'b0, 0, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, ramp(i + 40));

      // AVG with and without saturation
      load(8, 0, 1'b1, 3, 1'b0, '0);
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, splat(1000));
      check("avg_1000", 64'(dout[15:0]), 64'(1000));
      check("avg_1000_sat", 64'(dout_sat), 64'(0));
      load(8, 0, 1'b1, 0, 1'b0, '0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, splat(32'h7000));
      check("avg_pos_sat", 64'(dout[15:0]), 64'(16'h7FFF));
      check("avg_pos_flag", 64'(dout_sat), 64'(4'hF));
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, splat(-32768));
      check("avg_neg_sat", 64'(dout[15:0]), 64'(16'h8000));
      check("avg_neg_flag", 64'(dout_sat), 64'(4'hF));

      // cfg_load mid-frame with a coincident sample, then in an output cycle
      load(8, 0, 1'b1, 0, 1'b0, '0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, splat(10));
      load(8, 0, 1'b1, 0, 1'b1, splat(500));
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, splat(10));
      check("load_drop", 64'(dout[15:0]), 64'(80));
      for (int i = 0; i < 7; i++) step(1'b1, 1'b0, splat(3));
      load(8, 0, 1'b1, 0, 1'b1, splat(3));
      step(1'b0, 1'b0, '0);

      // Reset mid-frame, then defaults again
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, splat(7));
      #2;
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, dflt);
      check("post_rst_ch0", 64'(dout[15:0]), 64'(16'h1234));

      // Channel independence
      load(3, 0, 1'b1, 0, 1'b0, '0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, {16'h0000, 16'h7FFF, 16'hFF9C, 16'd100});
      check("chan_dout", 64'(dout), {16'h0000, 16'h7FFF, 16'hFED4, 16'h012C});
      check("chan_sat", 64'(dout_sat), 64'(4'b0100));

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
      check("queue_drained", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
